// File: rtl/aes_pkg.sv
// Shared AES-128 types, widths and GF(2^8) helpers used by the iterative encryption engine.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] rk,
  input  logic [7:0]             rcon,
  output logic [AES_BLOCK_W-1:0] rk_n
);
  logic [AES_WORD_W-1:0] rot_s, sub_s, tmp_s, w0_s, w1_s, w2_s, w3_s;

  assign rot_s = rot_word(rk[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sub_byte #(.NB(1)) u_sbox (.din(rot_s[8*i +: 8]), .dout(sub_s[8*i +: 8]));
  end

  assign tmp_s = sub_s ^ {rcon, 24'h000000};
  assign w0_s  = rk[127:96] ^ tmp_s;
  assign w1_s  = rk[95:64]  ^ w0_s;
  assign w2_s  = rk[63:32]  ^ w1_s;
  assign w3_s  = rk[31:0]   ^ w2_s;
  assign rk_n  = {w0_s, w1_s, w2_s, w3_s};
endmodule

// File: rtl/mix_columns.sv
// MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} circulant matrix.
module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0_s, a1_s, a2_s, a3_s;
    assign {a0_s, a1_s, a2_s, a3_s} = din[127-32*c -: 32];
    assign dout[127-32*c -: 32] = {
      xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s,
      a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s,
      a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s,
      xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s)
    };
  end
endmodule

// File: rtl/shift_rows.sv
// ShiftRows on a column-major state; byte r+4c sits at bits [127-8*(r+4c) -: 8].
module shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

// File: rtl/sub_byte.sv
// SubBytes over NB bytes; each byte goes through its own S-box lookup.
module sub_byte
  import aes_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic [8*NB-1:0] din,
  output logic [8*NB-1:0] dout
);
  for (genvar i = 0; i < NB; i++) begin : g_sbox
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryption engine: one shared round datapath reused for NR cycles per block,
// with on-the-fly key expansion and valid/ready handshakes on both sides.
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit FINAL_MIX = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out,
  output logic                   busy
);
  if ((NR < 1) || (NR > 10)) begin : g_nr_check
    $error("aes_iter_encrypt: NR must be in 1..10");
  end

  aes_state_e             state_r, state_s;
  logic [AES_BLOCK_W-1:0] st_r, rk_r, rk_n_s, sb_s, sr_s, mc_s, round_s, data_out_r;
  logic [7:0]             rcon_r;
  logic [3:0]             rnd_r;
  logic                   last_s, accept_s, release_s, out_valid_r, busy_r;

  aes_key_step u_key_step (.rk(rk_r), .rcon(rcon_r), .rk_n(rk_n_s));
  sub_byte #(.NB(16)) u_sub_byte (.din(st_r), .dout(sb_s));
  shift_rows  u_shift_rows  (.din(sb_s), .dout(sr_s));
  mix_columns u_mix_columns (.din(sr_s), .dout(mc_s));

  assign last_s  = (rnd_r == 4'(NR));
  // The standard cipher's final round skips MixColumns; FINAL_MIX keeps every round identical.
  assign round_s = (((last_s && (FINAL_MIX == 1'b0)) ? sr_s : mc_s)) ^ rk_n_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;

  // Next-state and handshake decode.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, round datapath registers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      st_r        <= 128'h0;
      rk_r        <= 128'h0;
      rcon_r      <= 8'h00;
      rnd_r       <= 4'd0;
      data_out_r  <= 128'h0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            st_r   <= data_in ^ key_in;
            rk_r   <= key_in;
            rcon_r <= 8'h01;
            rnd_r  <= 4'd1;
          end
        end
        RUN: begin
          st_r   <= round_s;
          rk_r   <= rk_n_s;
          rcon_r <= xtime(rcon_r);
          rnd_r  <= rnd_r + 4'd1;
          if (last_s) begin
            data_out_r  <= round_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (release_s) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end
endmodule
